onchip_mem_loader: RTL
======================

Name: onchip_mem_loader

Overview:
- Avalon-MM writer that sits directly upstream of the Nios on-chip program/data RAM (32-bit, 15-bit word address, single port, no waitrequest, one-cycle read latency).
- Takes a byte stream (e.g. from a UART/JTAG bridge), packs it little-endian into 32-bit words and writes them from word address 0 upward.
- Optionally reads the image back and checks a checksum.
- Holds the CPU in reset while the load is in progress.

Parameters:
ADDR_W, 15, word-address width of the target RAM
DEPTH, 25000, number of writable words; address DEPTH-1 is the last legal address
VERIFY_EN, 1, 1 = run a read-back checksum pass after the load; 0 = skip it

Ports:
clk  in  1  system clock
reset_n  in  1  reset, asynchronous assert, active low
start  in  1  single-cycle pulse that begins a load; ignored while busy=1
s_data  in  8  stream byte
s_valid  in  1  s_data is valid
s_last  in  1  marks the final byte of the image; qualified by s_valid
s_ready  out  1  byte is accepted when s_valid & s_ready
mem_address  out  ADDR_W  RAM word address
mem_byteenable  out  4  RAM byte lanes
mem_chipselect  out  1  RAM select
mem_write  out  1  RAM write strobe
mem_writedata  out  32  RAM write data
mem_readdata  in  32  RAM read data, valid the cycle after the address is presented
busy  out  1  high from start until DONE is entered
done  out  1  level; high in DONE until the next accepted start
error  out  1  overflow or verify mismatch; valid while done=1
cpu_reset_req  out  1  equals busy; holds the Nios core in reset
word_count  out  ADDR_W+1  number of words written, including a partial final word
checksum  out  32  sum mod 2^32 of all written words, with unfilled lanes counted as 0

Behaviour:
- Reset: every output is 0 and the FSM is in IDLE. Reset asserted mid-operation aborts immediately: mem_write and mem_chipselect drop asynchronously and the partial word is discarded.
- FSM states: IDLE, LOAD, DRAIN, VERIFY, DONE.
- IDLE or DONE, start=1:
  - clear the address, lane index, word_count, checksum and error;
  - next state is LOAD; busy=1; done=0.
- LOAD:
  - s_ready=1 every cycle, sustaining one byte per cycle.
  - An accepted byte goes into lane lane_idx of the assembly buffer; lane_idx then increments (2 bits).
- Word completion: the word completes on acceptance of lane 3, or on acceptance of a byte with s_last=1.
- Issuing the write: on the cycle after completion, registered outputs carry the word:
  - mem_write=1, mem_chipselect=1 for exactly one cycle;
  - mem_address = current address;
  - mem_byteenable = lanes filled (0001, 0011, 0111 or 1111);
  - unfilled data lanes = 0.
  - After the write: address +1, word_count +1, checksum += word.
  - The assembly buffer is freed in the completion cycle, so the stream never stalls.
- s_last accepted: after the final write the FSM goes to VERIFY if VERIFY_EN=1, otherwise to DONE.
- Overflow:
  - A word completes when address == DEPTH. No write is issued, error=1, next state is DRAIN.
  - In DRAIN, s_ready=1 and bytes are discarded until s_last, then the FSM goes to DONE. VERIFY is skipped.
- VERIFY (read-back pass):
  - s_ready=0; mem_chipselect=1, mem_write=0, mem_byteenable=1111.
  - Addresses 0..word_count-1 are issued one per cycle.
  - Each mem_readdata is sampled the following cycle. The final word is masked by its recorded byteenable before being summed.
  - One cycle after the last sample, compare the read sum with checksum. A mismatch sets error=1. Then go to DONE.
- DONE: busy=0, done=1; word_count and checksum hold their values.
- start while busy: ignored, no effect.
- s_valid without start: ignored; s_ready=0 outside LOAD and DRAIN.
- Width rules:
  - word_count is ADDR_W+1 bits so that DEPTH fits.
  - checksum and the read sum wrap mod 2^32.

Decomposition:
- Package onchip_mem_loader_pkg holds:
  - the FSM state enum;
  - the default ADDR_W and DEPTH;
  - a function that maps lane count to a byteenable mask.
- Sub-module mem_loader_packer handles byte-to-word assembly: lane index, buffer, completion pulse and byteenable.
- The FSM, address counter, write register and verify pass stay in the top level.

Test Plan:
- Stream 0x11..0x88 (8 bytes, last on 0x88), s_valid continuous:
  - writes addr0 = 0x44332211 with be=1111, then addr1 = 0x88776655 with be=1111;
  - word_count=2, checksum=0xCCAA8866, done=1, error=0.
- Stream 0x01..0x05 (5 bytes):
  - addr1 is written as 0x00000005 with be=0001;
  - word_count=2, checksum=0x04030206, verify passes.
- Same 8-byte stream with the bench RAM model corrupting addr1 on read (0x88776654) -> error=1 and done=1, after reads of addresses 0 and 1.
- DEPTH=4, 20 bytes:
  - exactly 4 writes at addresses 0..3, no write to address 4;
  - s_ready stays 1 through s_last; error=1, word_count=4, VERIFY skipped.
- 400 continuous bytes -> s_ready never drops, 100 writes issued one every 4 cycles, cpu_reset_req=1 for the whole load.
- Either of the following in the middle of a load:
  - start pulsed -> no restart;
  - reset_n pulled low -> mem_write=0 and busy=0 immediately, and after release the next start loads from address 0.

Source files
------------

// File: rtl/onchip_mem_loader_pkg.sv
// Shared FSM encoding, default geometry and byte-lane helpers for the on-chip RAM loader.
package onchip_mem_loader_pkg;

    localparam int DEF_ADDR_W = 15;
    localparam int DEF_DEPTH  = 25000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_VERIFY = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    function automatic logic [3:0] lanes_to_be(input logic [2:0] lanes);
        logic [3:0] be;
        case (lanes)
            3'd1:    be = 4'b0001;
            3'd2:    be = 4'b0011;
            3'd3:    be = 4'b0111;
            3'd4:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] be_to_mask(input logic [3:0] be);
        logic [31:0] mask;
        for (int i = 0; i < 4; i++) begin
            mask[8*i +: 8] = {8{be[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/mem_loader_packer.sv
// Packs accepted stream bytes little-endian into 32-bit words and flags word completion.
module mem_loader_packer
    import onchip_mem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear_i,
    input  logic        accept_i,
    input  logic [7:0]  data_i,
    input  logic        last_i,
    output logic        word_done_o,
    output logic [31:0] word_data_o,
    output logic [3:0]  word_be_o,
    output logic        word_last_o
);

    logic [1:0]  lane_q, lane_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] merged;

    // The completing byte is merged combinationally so the buffer can be reused next cycle.
    always_comb begin
        merged = acc_q;
        merged[{lane_q, 3'b000} +: 8] = data_i;
    end

    assign word_done_o = accept_i && ((lane_q == 2'd3) || last_i);
    assign word_last_o = accept_i && last_i;
    assign word_be_o   = lanes_to_be({1'b0, lane_q} + 3'd1);
    assign word_data_o = merged & be_to_mask(word_be_o);

    always_comb begin
        lane_d = lane_q;
        acc_d  = acc_q;
        if (clear_i) begin
            lane_d = 2'd0;
            acc_d  = '0;
        end else if (accept_i) begin
            if (word_done_o) begin
                lane_d = 2'd0;
                acc_d  = '0;
            end else begin
                lane_d = lane_q + 2'd1;
                acc_d  = merged;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lane_q <= 2'd0;
            acc_q  <= '0;
        end else begin
            lane_q <= lane_d;
            acc_q  <= acc_d;
        end
    end

endmodule

// File: rtl/onchip_mem_loader.sv
// Streams a byte image into the Nios on-chip RAM, optionally reads it back to confirm
// the checksum, and holds the CPU in reset for the duration.
module onchip_mem_loader
    import onchip_mem_loader_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int VERIFY_EN = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    input  logic [31:0]       mem_readdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              cpu_reset_req,
    output logic [ADDR_W:0]   word_count,
    output logic [31:0]       checksum
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    state_e            state_q, state_d;
    logic [ADDR_W:0]   wc_q, rd_ptr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        be_q, last_be_q;
    logic              cs_q, wr_q, err_q;
    logic [31:0]       wdata_q, csum_q, rsum_q;
    logic              p1_q, p1_last_q, p2_q, p2_last_q, cmp_q;

    logic        in_load, start_ok, accept, overflow;
    logic        word_done, word_last;
    logic [31:0] word_data, rd_word;
    logic [3:0]  word_be;

    assign in_load  = (state_q == ST_LOAD);
    assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign accept   = s_valid && in_load;
    assign overflow = (wc_q == DEPTH_C);
    assign rd_word  = p2_last_q ? (mem_readdata & be_to_mask(last_be_q)) : mem_readdata;

    mem_loader_packer u_packer (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear_i     (start_ok),
        .accept_i    (accept),
        .data_i      (s_data),
        .last_i      (s_last),
        .word_done_o (word_done),
        .word_data_o (word_data),
        .word_be_o   (word_be),
        .word_last_o (word_last)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: if (start) state_d = ST_LOAD;
            ST_LOAD: begin
                if (word_done) begin
                    if (overflow) begin
                        state_d = word_last ? ST_DONE : ST_DRAIN;
                    end else if (word_last) begin
                        state_d = (VERIFY_EN != 0) ? ST_VERIFY : ST_DONE;
                    end
                end
            end
            ST_DRAIN:  if (s_valid && s_last) state_d = ST_DONE;
            ST_VERIFY: if (cmp_q) state_d = ST_DONE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Read-back is a three-deep pipe: issue, RAM latency, sample; the compare follows the last sample.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            wc_q      <= '0;
            rd_ptr_q  <= '0;
            addr_q    <= '0;
            be_q      <= '0;
            last_be_q <= '0;
            cs_q      <= 1'b0;
            wr_q      <= 1'b0;
            err_q     <= 1'b0;
            wdata_q   <= '0;
            csum_q    <= '0;
            rsum_q    <= '0;
            p1_q      <= 1'b0;
            p1_last_q <= 1'b0;
            p2_q      <= 1'b0;
            p2_last_q <= 1'b0;
            cmp_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cs_q      <= 1'b0;
            wr_q      <= 1'b0;
            p1_q      <= 1'b0;
            p2_q      <= p1_q;
            p2_last_q <= p1_last_q;
            cmp_q     <= 1'b0;
            if (start_ok) begin
                wc_q     <= '0;
                rd_ptr_q <= '0;
                csum_q   <= '0;
                rsum_q   <= '0;
                err_q    <= 1'b0;
            end
            if (in_load && word_done) begin
                if (overflow) begin
                    err_q <= 1'b1;
                end else begin
                    cs_q      <= 1'b1;
                    wr_q      <= 1'b1;
                    addr_q    <= wc_q[ADDR_W-1:0];
                    be_q      <= word_be;
                    wdata_q   <= word_data;
                    last_be_q <= word_be;
                    wc_q      <= wc_q + 1'b1;
                    csum_q    <= csum_q + word_data;
                end
            end
            if (state_q == ST_VERIFY) begin
                if (rd_ptr_q < wc_q) begin
                    cs_q      <= 1'b1;
                    be_q      <= 4'b1111;
                    addr_q    <= rd_ptr_q[ADDR_W-1:0];
                    rd_ptr_q  <= rd_ptr_q + 1'b1;
                    p1_q      <= 1'b1;
                    p1_last_q <= ((rd_ptr_q + 1'b1) == wc_q);
                end
                if (p2_q) begin
                    rsum_q <= rsum_q + rd_word;
                    cmp_q  <= p2_last_q;
                end
                if (cmp_q && (rsum_q != csum_q)) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign s_ready        = in_load || (state_q == ST_DRAIN);
    assign busy           = in_load || (state_q == ST_DRAIN) || (state_q == ST_VERIFY);
    assign done           = (state_q == ST_DONE);
    assign cpu_reset_req  = busy;
    assign error          = err_q;
    assign word_count     = wc_q;
    assign checksum       = csum_q;
    assign mem_address    = addr_q;
    assign mem_byteenable = be_q;
    assign mem_chipselect = cs_q;
    assign mem_write      = wr_q;
    assign mem_writedata  = wdata_q;

endmodule
